// File: rtl/int_pulse_coder.sv
// int_pulse_coder
//   Upstream encoder for the single-wire coded interrupt line. Runs a free 1 us prescaler
//   (t1us tick) and, on request, drives int_out high for a whole number of microseconds aligned
//   to tick boundaries, followed by a low guard interval.
// Ports
//   clk        system clock
//   rst_n      asynchronous reset, active low
//   req_valid  request present
//   req_code   1 = W_CODE1, 2 = W_CODE2, 3 = req_width, 0 = illegal
//   req_width  pulse width in us for code 3 (1..255)
//   req_ready  request can be accepted this cycle (idle and no abort)
//   abort      cuts the pulse in progress
//   int_out    coded interrupt line (registered)
//   t1us       1 us tick, ~50% duty (registered)
//   busy       FSM not idle (registered)
//   err        one-cycle pulse when an illegal request is consumed (registered)
module int_pulse_coder #(
    parameter int unsigned CLK_PER_US = 100,
    parameter int unsigned W_CODE1    = 10,
    parameter int unsigned W_CODE2    = 30,
    parameter int unsigned GUARD_US   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [1:0] req_code,
    input  logic [7:0] req_width,
    output logic       req_ready,
    input  logic       abort,
    output logic       int_out,
    output logic       t1us,
    output logic       busy,
    output logic       err
);

    localparam int unsigned PW         = $clog2(CLK_PER_US);
    localparam logic [PW-1:0] PCNT_LAST = PW'(CLK_PER_US - 1);
    localparam logic [PW-1:0] PCNT_HALF = PW'(CLK_PER_US / 2);
    // GUARD_US = 256 maps to 255, the last value of the 8-bit counter
    localparam logic [7:0] GUARD_LAST  = 8'(GUARD_US - 1);
    localparam logic [7:0] WID1        = 8'(W_CODE1);
    localparam logic [7:0] WID2        = 8'(W_CODE2);

    generate
        if (CLK_PER_US < 4) begin : g_chk_clk
            $error("CLK_PER_US must be >= 4");
        end
        if (GUARD_US < 1 || GUARD_US > 256) begin : g_chk_guard
            $error("GUARD_US must be in 1..256");
        end
        if (W_CODE1 < 1 || W_CODE1 > 255 || W_CODE2 < 1 || W_CODE2 > 255) begin : g_chk_wid
            $error("W_CODE1/W_CODE2 must be in 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StAlign, StPulse, StGuard} state_e;

    state_e        state_q;
    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic [7:0]    wid_q;
    logic [7:0]    us_cnt_q;
    logic          skip_q;
    logic          us_stb;
    logic          xfer;
    logic          illegal;
    logic [7:0]    req_wid;

    always_comb begin
        us_stb = (pcnt_q == PCNT_LAST);
        pcnt_d = us_stb ? '0 : pcnt_q + PW'(1);
    end

    assign req_ready = (state_q == StIdle) && !abort;
    assign xfer      = req_valid && req_ready;
    assign illegal   = (req_code == 2'd0) || ((req_code == 2'd3) && (req_width == 8'd0));

    always_comb begin
        req_wid = req_width;
        unique case (req_code)
            2'd1:    req_wid = WID1;
            2'd2:    req_wid = WID2;
            default: req_wid = req_width;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pcnt_q   <= '0;
            wid_q    <= '0;
            us_cnt_q <= '0;
            skip_q   <= 1'b0;
            int_out  <= 1'b0;
            t1us     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            t1us   <= (pcnt_d < PCNT_HALF);
            err    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (xfer) begin
                        if (illegal) begin
                            err <= 1'b1;
                        end else begin
                            wid_q   <= req_wid;
                            state_q <= StAlign;
                            busy    <= 1'b1;
                        end
                    end
                end
                StAlign: begin
                    if (abort) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else if (us_stb) begin
                        int_out  <= 1'b1;
                        us_cnt_q <= '0;
                        state_q  <= StPulse;
                    end
                end
                StPulse: begin
                    if (abort) begin
                        int_out  <= 1'b0;
                        us_cnt_q <= '0;
                        // An off-tick abort leaves a partial microsecond before the next tick;
                        // skip that tick so the guard still spans GUARD_US whole microseconds.
                        skip_q   <= !us_stb;
                        state_q  <= StGuard;
                    end else if (us_stb) begin
                        if (us_cnt_q == wid_q - 8'd1) begin
                            int_out  <= 1'b0;
                            us_cnt_q <= '0;
                            state_q  <= StGuard;
                        end else begin
                            us_cnt_q <= us_cnt_q + 8'd1;
                        end
                    end
                end
                StGuard: begin
                    if (us_stb) begin
                        if (skip_q) begin
                            skip_q <= 1'b0;
                        end else if (us_cnt_q == GUARD_LAST) begin
                            us_cnt_q <= '0;
                            state_q  <= StIdle;
                            busy     <= 1'b0;
                        end else begin
                            us_cnt_q <= us_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    int_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_pulse_coder.sv
`timescale 1ns/1ps
module tb_int_pulse_coder;

    localparam int CPU = 100;
    localparam int G   = 20;

    typedef struct {
        int width;    // expected high time in clk
        int cls;      // expected decoder result: 0 none, 1 INT1, 2 INT2
        bit aborted;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_code = 2'd0;
    logic [7:0] req_width = 8'd0;
    logic       abort = 1'b0;
    logic       req_ready, int_out, t1us, busy, err;

    logic       rst_n4 = 1'b0;
    logic       rv4 = 1'b0;
    logic [1:0] code4 = 2'd0;
    logic [7:0] w4 = 8'd0;
    logic       rdy4, int4, t1us4, busy4, err4;

    always #5 clk = ~clk;

    int_pulse_coder #(.CLK_PER_US(CPU), .W_CODE1(10), .W_CODE2(30), .GUARD_US(G)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_code(req_code),
        .req_width(req_width), .req_ready(req_ready), .abort(abort), .int_out(int_out),
        .t1us(t1us), .busy(busy), .err(err)
    );

    int_pulse_coder #(.CLK_PER_US(4), .W_CODE1(10), .W_CODE2(30), .GUARD_US(G)) u4 (
        .clk(clk), .rst_n(rst_n4), .req_valid(rv4), .req_code(code4),
        .req_width(w4), .req_ready(rdy4), .abort(1'b0), .int_out(int4),
        .t1us(t1us4), .busy(busy4), .err(err4)
    );

    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t q[$];
    int   q4[$];
    int   err_hi = 0;
    int   err_exp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo,
                               input longint hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out, got no event, expected one", name);
    endtask

    function automatic int decode(input int w, input int cpu);
        int us;
        us = w / cpu;
        if (us >= 5 && us <= 15) return 1;
        if (us >= 25 && us <= 35) return 2;
        return 0;
    endfunction

    task automatic wait_busy_low(input int max, input string name);
        for (int i = 0; i < max && busy; i++) @(negedge clk);
        if (busy) timeout(name);
    endtask

    task automatic wait_rise(input int max, input string name);
        for (int i = 0; i < max && !int_out; i++) @(negedge clk);
        if (!int_out) timeout(name);
    endtask

    task automatic send(input logic [1:0] code, input logic [7:0] w, output int acc);
        @(negedge clk);
        req_valid = 1'b1;
        req_code  = code;
        req_width = w;
        for (int i = 0; i < 5000 && !req_ready; i++) @(negedge clk);
        if (!req_ready) timeout("send_ready");
        acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Monitor / scoreboard for the main instance
    initial begin : mon
        int   hi_cnt, gd_cnt, last_fall;
        bit   in_pulse, in_guard, have_fall;
        logic int_prev, t1us_prev;
        exp_t cur;
        hi_cnt = 0; gd_cnt = 0; last_fall = 0;
        in_pulse = 0; in_guard = 0; have_fall = 0;
        int_prev = 0; t1us_prev = 0;
        cur = '{width: 0, cls: 0, aborted: 0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_pulse = 0; in_guard = 0; have_fall = 0;
            end else begin
                if (int_out && !int_prev) begin
                    check("rise_on_tick", {t1us_prev, t1us}, 2'b01);
                    if (have_fall) check_range("guard_gap", cyc - last_fall, G * CPU, 1 << 30);
                    in_pulse = 1; hi_cnt = 0; in_guard = 0;
                end
                if (int_out) hi_cnt++;
                if (!int_out && int_prev && in_pulse) begin
                    in_pulse = 0;
                    if (q.size() == 0) begin
                        check("unexpected_pulse", hi_cnt, 0);
                    end else begin
                        cur = q.pop_front();
                        check("pulse_width", hi_cnt, cur.width);
                        check("decoder_class", decode(hi_cnt, CPU), cur.cls);
                        in_guard = 1; gd_cnt = 0; last_fall = cyc; have_fall = 1;
                    end
                end
                if (in_guard) begin
                    if (busy) begin
                        gd_cnt++;
                    end else begin
                        in_guard = 0;
                        if (cur.aborted) check_range("guard_abort", gd_cnt, G * CPU, G * CPU + CPU);
                        else             check("guard_len", gd_cnt, G * CPU);
                    end
                end
            end
            int_prev  = int_out;
            t1us_prev = t1us;
            if (err) err_hi++;
        end
    end

    // Monitor for the CLK_PER_US=4 instance
    initial begin : mon4
        int   hi4, lf4;
        bit   hf4;
        logic p4;
        hi4 = 0; lf4 = 0; hf4 = 0; p4 = 0;
        forever begin
            @(negedge clk);
            if (rst_n4) begin
                if (int4 && !p4) begin
                    if (hf4) check_range("gap_4", cyc - lf4, G * 4, 1 << 30);
                    hi4 = 0;
                end
                if (int4) hi4++;
                if (!int4 && p4) begin
                    if (q4.size() == 0) check("unexpected_pulse_4", hi4, 0);
                    else                check("width_4", hi4, q4.pop_front());
                    lf4 = cyc; hf4 = 1;
                end
            end
            p4 = int4;
        end
    end

    initial begin : stim
        int acc, hi, lo, viol, cnt;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_int_out", int_out, 0);
        check("rst_busy", busy, 0);
        check("rst_t1us", t1us, 0);
        check("rst_err", err, 0);
        check("rst_ready", req_ready, 1);
        rst_n = 1'b1;
        rst_n4 = 1'b1;

        // 1) tick shape, idle outputs
        for (int i = 0; i < 300 && !t1us; i++) @(negedge clk);
        for (int i = 0; i < 300 && t1us; i++) @(negedge clk);
        for (int i = 0; i < 300 && !t1us; i++) @(negedge clk);
        hi = 0; lo = 0;
        for (int i = 0; i < 300 && t1us; i++) begin hi++; @(negedge clk); end
        for (int i = 0; i < 300 && !t1us; i++) begin lo++; @(negedge clk); end
        check("t1us_high", hi, CPU / 2);
        check("t1us_period", hi + lo, CPU);
        check("idle_int_out", int_out, 0);
        check("idle_busy", busy, 0);

        // 2) code 1
        q.push_back('{width: 10 * CPU, cls: 1, aborted: 0});
        send(2'd1, 8'd0, acc);
        wait_rise(200, "code1_rise");
        check_range("code1_latency", cyc - acc, 1, CPU);
        wait_busy_low(4000, "code1_busy");

        // 3) code 2 then code 3 width 1, req_valid held
        q.push_back('{width: 30 * CPU, cls: 2, aborted: 0});
        q.push_back('{width: CPU, cls: 0, aborted: 0});
        @(negedge clk);
        req_valid = 1'b1; req_code = 2'd2; req_width = 8'd0;
        @(negedge clk);
        req_code = 2'd3; req_width = 8'd1;
        viol = 0;
        for (int i = 0; i < 6000 && busy; i++) begin
            if (req_ready) viol++;
            @(negedge clk);
        end
        if (busy) timeout("held_first_busy");
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 3000 && busy; i++) begin
            if (req_ready) viol++;
            @(negedge clk);
        end
        if (busy) timeout("held_second_busy");
        check("held_ready_low", viol, 0);

        // 4) illegal requests
        send(2'd0, 8'd0, acc);
        err_exp++;
        send(2'd3, 8'd0, acc);
        err_exp++;
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            if (busy || int_out) cnt++;
            @(negedge clk);
        end
        check("illegal_no_activity", cnt, 0);

        // 5) widest pulse
        q.push_back('{width: 255 * CPU, cls: 0, aborted: 0});
        send(2'd3, 8'd255, acc);
        wait_busy_low(30000, "w255_busy");

        // 6) abort on a tick boundary, then off-tick
        q.push_back('{width: 400, cls: 0, aborted: 1});
        send(2'd1, 8'd0, acc);
        wait_rise(200, "abort400_rise");
        repeat (399) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort400_fall", int_out, 0);
        wait_busy_low(3000, "abort400_busy");

        q.push_back('{width: 450, cls: 0, aborted: 1});
        send(2'd1, 8'd0, acc);
        wait_rise(200, "abort450_rise");
        repeat (449) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort450_fall", int_out, 0);
        wait_busy_low(3000, "abort450_busy");

        // abort during ALIGN: no pulse
        send(2'd1, 8'd0, acc);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("align_abort_busy", busy, 0);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (int_out) cnt++;
            @(negedge clk);
        end
        check("align_abort_no_pulse", cnt, 0);

        // abort in IDLE blocks the handshake
        req_valid = 1'b1; req_code = 2'd1; abort = 1'b1;
        #1;
        check("idle_abort_ready", req_ready, 0);
        @(negedge clk);
        req_valid = 1'b0; abort = 1'b0;
        check("idle_abort_busy", busy, 0);

        // reset mid-pulse
        send(2'd2, 8'd0, acc);
        wait_rise(200, "rst_rise");
        repeat (500) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_int_out", int_out, 0);
        check("rst_async_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_restart_ready", req_ready, 1);
        q.push_back('{width: CPU, cls: 0, aborted: 0});
        send(2'd3, 8'd1, acc);
        check_range("rst_restart_latency", cyc - acc, 0, 1 << 30);
        wait_rise(200, "rst_restart_rise");
        wait_busy_low(3000, "rst_restart_busy");

        // CLK_PER_US = 4: code 1, then code 2 / code 3 width 1 with valid held
        q4.push_back(40);
        @(negedge clk);
        rv4 = 1'b1; code4 = 2'd1; w4 = 8'd0;
        @(negedge clk);
        rv4 = 1'b0;
        for (int i = 0; i < 500 && busy4; i++) @(negedge clk);
        if (busy4) timeout("c4_code1_busy");
        q4.push_back(120);
        q4.push_back(4);
        rv4 = 1'b1; code4 = 2'd2;
        @(negedge clk);
        code4 = 2'd3; w4 = 8'd1;
        for (int i = 0; i < 1000 && busy4; i++) @(negedge clk);
        if (busy4) timeout("c4_held_busy");
        @(negedge clk);
        rv4 = 1'b0;
        for (int i = 0; i < 500 && busy4; i++) @(negedge clk);
        if (busy4) timeout("c4_second_busy");

        repeat (5) @(negedge clk);
        check("err_cycles", err_hi, err_exp);
        check("scoreboard_drained", q.size(), 0);
        check("scoreboard4_drained", q4.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
